painterengine_gpu_fifo_reader: RTL and testbench

Read-side consumer for painterengine_gpu_fifo. On a start command it pops exactly LENGTH words from the FIFO read port, absorbing the FIFO's 1-cycle read latency. It forwards the words on a valid/ready stream toward the GPU pixel pipeline, using a 2-entry output buffer so a downstream stall never loses data. Single clock domain: the FIFO read clock.

---
 rtl/painterengine_gpu_pkg.sv | 12 +
 rtl/painterengine_gpu_fifo_reader_if.sv | 33 +++
 rtl/painterengine_gpu_skid_buffer.sv | 62 ++++++
 rtl/painterengine_gpu_fifo_reader.sv | 107 ++++++++++
 tb/tb_painterengine_gpu_fifo_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the GPU stream stages: reader FSM encoding and default word width.
package painterengine_gpu_pkg;

  localparam int GPU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } reader_state_t;

endpackage

// File: rtl/painterengine_gpu_fifo_reader_if.sv
// FIFO read port plus outgoing valid/ready word stream of the GPU fifo reader.
interface painterengine_gpu_fifo_reader_if
  import painterengine_gpu_pkg::*;
#(
  parameter int DATA_WIDTH = GPU_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] i_wire_fifo_data;
  logic                  i_wire_fifo_empty;
  logic                  o_wire_fifo_read;
  logic [DATA_WIDTH-1:0] o_wire_data;
  logic                  o_wire_valid;
  logic                  i_wire_ready;

  modport master (
    input  i_wire_fifo_data,
    input  i_wire_fifo_empty,
    input  i_wire_ready,
    output o_wire_fifo_read,
    output o_wire_data,
    output o_wire_valid
  );

  modport slave (
    output i_wire_fifo_data,
    output i_wire_fifo_empty,
    output i_wire_ready,
    input  o_wire_fifo_read,
    input  o_wire_data,
    input  o_wire_valid
  );

endinterface

// File: rtl/painterengine_gpu_skid_buffer.sv
// Purpose: 2-entry in-order valid/ready word buffer that reports its occupancy.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: holds head stable while pop_rdy=0; push into a full buffer is dropped unless a pop frees a slot.
module painterengine_gpu_skid_buffer
  import painterengine_gpu_pkg::*;
#(
  parameter int DATA_WIDTH = GPU_DATA_WIDTH
) (
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push_vld,
  input  logic [DATA_WIDTH-1:0] push_dat,
  output logic                  pop_vld,
  input  logic                  pop_rdy,
  output logic [DATA_WIDTH-1:0] pop_dat,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            occ_q;
  logic                  pop;
  logic                  push_ok;

  assign pop       = pop_vld && pop_rdy;
  assign push_ok   = push_vld && ((occ_q != 2'd2) || pop);
  assign pop_vld   = (occ_q != 2'd0);
  assign pop_dat   = head_q;
  assign occupancy = occ_q;

  always_ff @(posedge core_clk) begin
    if (rst || clr) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= push_dat;
          else               tail_q <= push_dat;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        // Simultaneous push and pop: the incoming word joins behind whatever remains.
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= push_dat;
          end else begin
            head_q <= tail_q;
            tail_q <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/painterengine_gpu_fifo_reader.sv
// Purpose: pops exactly LENGTH words from the FIFO read port and streams them out on valid/ready.
// Latency: first valid 3 cycles after start (RUN entry, pop, capture); then 1 word/cycle.
// Backpressure: ready=0 holds the stream head; pops stop once buffered + in-flight words would exceed 2.
module painterengine_gpu_fifo_reader
  import painterengine_gpu_pkg::*;
#(
  parameter int DATA_WIDTH   = GPU_DATA_WIDTH,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    i_wire_clock,
  input  logic                    i_wire_reset,
  input  logic                    i_wire_start,
  input  logic [LENGTH_WIDTH-1:0] i_wire_length,
  painterengine_gpu_fifo_reader_if.master bus,
  output logic                    o_wire_busy,
  output logic                    o_wire_done,
  output logic [LENGTH_WIDTH-1:0] o_wire_count
);

  reader_state_t           state_q;
  reader_state_t           state_d;
  logic [LENGTH_WIDTH-1:0] length_q;
  logic [LENGTH_WIDTH-1:0] issued_q;
  logic [LENGTH_WIDTH-1:0] count_q;
  logic                    inflight_q;
  logic [1:0]              occupancy;
  logic                    accept;
  logic                    last_accept;
  logic                    start_ok;
  logic                    fifo_read;
  logic                    room;

  assign start_ok    = (state_q == IDLE) && i_wire_start;
  assign accept      = bus.o_wire_valid && bus.i_wire_ready;
  assign last_accept = accept && ((count_q + LENGTH_WIDTH'(1)) == length_q);

  // The word leaving downstream this cycle frees its slot in time for a pop
  // issued now, which is what sustains one word per cycle with a 2-entry buffer.
  assign room = ({1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, accept}) < 3'd2;

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_wire_start) state_d = (i_wire_length == '0) ? FINISH : RUN;
      RUN:     if (last_accept) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_read   = 1'b0;
    o_wire_busy = 1'b0;
    o_wire_done = 1'b0;
    case (state_q)
      RUN: begin
        o_wire_busy = 1'b1;
        fifo_read   = !i_wire_reset && !bus.i_wire_fifo_empty &&
                      (issued_q < length_q) && room;
      end
      FINISH:  o_wire_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_wire_fifo_read = fifo_read;
  assign o_wire_count         = count_q;

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      length_q   <= '0;
      issued_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_read;
      if (start_ok) begin
        length_q <= i_wire_length;
        issued_q <= '0;
        count_q  <= '0;
      end else begin
        if (fifo_read) issued_q <= issued_q + LENGTH_WIDTH'(1);
        if (accept)    count_q  <= count_q + LENGTH_WIDTH'(1);
      end
    end
  end

  painterengine_gpu_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .core_clk  (i_wire_clock),
    .rst       (i_wire_reset),
    .clr       (start_ok),
    .push_vld  (inflight_q),
    .push_dat  (bus.i_wire_fifo_data),
    .pop_vld   (bus.o_wire_valid),
    .pop_rdy   (bus.i_wire_ready),
    .pop_dat   (bus.o_wire_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_painterengine_gpu_fifo_reader.sv
// Directed bench: FIFO model with 1-cycle read latency, scoreboard of expected stream words.
module tb_painterengine_gpu_fifo_reader;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [LW-1:0] count;

  always #5 clk = ~clk;

  painterengine_gpu_fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

  painterengine_gpu_fifo_reader #(
    .DATA_WIDTH   (DW),
    .LENGTH_WIDTH (LW)
  ) dut (
    .i_wire_clock  (clk),
    .i_wire_reset  (rst),
    .i_wire_start  (start),
    .i_wire_length (length),
    .bus           (bus),
    .o_wire_busy   (busy),
    .o_wire_done   (done),
    .o_wire_count  (count)
  );

  // FIFO model: words are staged at fill_ptr and become visible when wr_ptr advances.
  logic [DW-1:0] fmem [0:511];
  logic [8:0]    wr_ptr;
  logic [8:0]    fill_ptr;
  logic [8:0]    rd_ptr = '0;
  logic [DW-1:0] next_val;
  logic [DW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int outst = 0;
  int read_cnt, done_cnt, valid_cnt, busy_cnt, acc_cnt;
  int first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cyc, start_cyc;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  assign bus.i_wire_fifo_empty = (wr_ptr == rd_ptr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) outst <= 0;
    else outst <= outst + ((bus.o_wire_fifo_read && !bus.i_wire_fifo_empty) ? 1 : 0)
                        - ((bus.o_wire_valid && bus.i_wire_ready) ? 1 : 0);
    if (bus.o_wire_fifo_read && !bus.i_wire_fifo_empty) begin
      bus.i_wire_fifo_data <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 9'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_wire_fifo_read) begin
        read_cnt++;
        chk("read_when_empty", bus.i_wire_fifo_empty, 0);
        chk("read_overflow", ((outst - ((bus.o_wire_valid && bus.i_wire_ready) ? 1 : 0)) < 2), 1);
      end
      if (bus.o_wire_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall) begin
        chk("stall_valid", bus.o_wire_valid, 1);
        chk("stall_data", bus.o_wire_data, prev_dat);
      end
      if (bus.o_wire_valid && bus.i_wire_ready) begin
        chk("word_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("stream_data", bus.o_wire_data, exp_q.pop_front());
        acc_cnt++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      prev_stall = bus.o_wire_valid && !bus.i_wire_ready;
      prev_dat   = bus.o_wire_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic stage(input int n, input bit publish);
    for (int i = 0; i < n; i++) begin
      fmem[fill_ptr] = next_val;
      next_val = next_val + 1;
      fill_ptr = fill_ptr + 9'd1;
    end
    if (publish) wr_ptr = fill_ptr;
  endtask

  task automatic clear_stats();
    read_cnt = 0; done_cnt = 0; valid_cnt = 0; busy_cnt = 0; acc_cnt = 0;
    first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic do_start(input int len);
    @(posedge clk); #1;
    start = 1'b1;
    length = LW'(len);
    start_cyc = cyc;
    for (int i = 0; i < len; i++) exp_q.push_back(fmem[rd_ptr + 9'(i)]);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 1 toggles ready every cycle; gap>0 publishes one staged word every gap cycles.
  task automatic wait_done(input int mode, input int gap, input int budget);
    bit seen = 1'b0;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(posedge clk); #1;
      if (mode == 1) bus.i_wire_ready = ~bus.i_wire_ready;
      if (gap > 0 && (i % gap) == 0 && wr_ptr != fill_ptr) wr_ptr = wr_ptr + 9'd1;
      if (done_cnt > 0) seen = 1'b1;
    end
    chk("done_within_budget", seen, 1);
    bus.i_wire_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; length = '0;
    bus.i_wire_ready = 1'b0;
    wr_ptr = '0; fill_ptr = '0; next_val = 1;
    clear_stats();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.o_wire_valid, 0);
    chk("rst_read", bus.o_wire_fifo_read, 0);
    chk("rst_count", count, 0);
    chk("rst_data", bus.o_wire_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_wire_ready = 1'b1;

    // 64 words, ready held high: full-rate streaming
    stage(64, 1'b1);
    clear_stats();
    do_start(64);
    wait_done(0, 0, 300);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_reads", read_cnt, 64);
    chk("t1_count", count, 64);
    chk("t1_queue_drained", exp_q.size(), 0);
    chk("t1_first_valid_latency", first_valid_cyc - start_cyc, 3);
    chk("t1_back_to_back", last_acc_cyc - first_acc_cyc, 63);
    chk("t1_done_after_last", done_cyc - last_acc_cyc, 1);
    chk("t1_busy_cycles", busy_cnt, 66);

    // 16 words with ready toggling every cycle
    stage(16, 1'b1);
    clear_stats();
    do_start(16);
    wait_done(1, 0, 300);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_reads", read_cnt, 16);
    chk("t2_count", count, 16);
    chk("t2_accepts", acc_cnt, 16);
    chk("t2_queue_drained", exp_q.size(), 0);

    // FIFO starts empty, words trickle in every 7 cycles
    stage(5, 1'b0);
    clear_stats();
    do_start(5);
    chk("t3_empty_no_read", read_cnt, 0);
    wait_done(0, 7, 300);
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_reads", read_cnt, 5);
    chk("t3_count", count, 5);
    chk("t3_queue_drained", exp_q.size(), 0);
    chk("t3_done_after_last", done_cyc - last_acc_cyc, 1);

    // Zero-length transfer
    clear_stats();
    do_start(0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_done_timing", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
    chk("t4_reads", read_cnt, 0);
    chk("t4_valid", valid_cnt, 0);
    chk("t4_busy", busy_cnt, 0);
    chk("t4_count", count, 0);

    // Reset after 10 of 32 words, then a fresh 4-word transfer
    stage(32, 1'b1);
    clear_stats();
    do_start(32);
    for (int i = 0; i < 200 && acc_cnt < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_accepts_before_reset", acc_cnt, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    clear_stats();
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", bus.o_wire_valid, 0);
    chk("t5_rst_read", bus.o_wire_fifo_read, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_data", bus.o_wire_data, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle_no_read", read_cnt, 0);
    chk("t5_idle_no_valid", valid_cnt, 0);
    do_start(4);
    wait_done(0, 0, 100);
    chk("t5_done_pulses", done_cnt, 1);
    chk("t5_reads", read_cnt, 4);
    chk("t5_count", count, 4);
    chk("t5_queue_drained", exp_q.size(), 0);

    // Second start while busy must be ignored
    clear_stats();
    do_start(8);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    length = LW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 0, 100);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_done_pulses", done_cnt, 1);
    chk("t6_reads", read_cnt, 8);
    chk("t6_count", count, 8);
    chk("t6_queue_drained", exp_q.size(), 0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_valid", bus.o_wire_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
